// File: rtl/gf_reduce.sv
// -----------------------------------------------------------------------------
// gf_reduce
//   Reduces an unreduced carry-less product modulo a field polynomial of
//   degree m (1..DATA_WIDTH), one polynomial degree per clock cycle, using
//   an IDLE -> REDUCE -> DONE state machine.
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   resetn       synchronous active-low reset
//   enable       start request, sampled only in IDLE
//   in_width     field degree m for the operation
//   in_poly      modulus polynomial (bit m implicit, bits above m ignored)
//   in_product   unreduced carry-less product
//   out_reduced  registered result, bits m and above read 0
//   op_finish    registered one-cycle completion pulse
//   out_error    registered, set with op_finish when in_width is invalid
//   busy         high whenever the FSM is not in IDLE
//
// Configuration macro
//   GF_REDUCE_EARLY_EXIT_EN  finish as soon as the bits at and above degree m
//                            of the remainder are all zero (variable latency)
// -----------------------------------------------------------------------------
module gf_reduce #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic [$clog2(DATA_WIDTH):0]   in_width,
  input  logic [DATA_WIDTH:0]           in_poly,
  input  logic [2*DATA_WIDTH-1:0]       in_product,
  output logic [DATA_WIDTH-1:0]         out_reduced,
  output logic                          op_finish,
  output logic                          out_error,
  output logic                          busy
);

  localparam int WW = $clog2(DATA_WIDTH) + 1;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int IW = $clog2(PW);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WW-1:0]         m_q, m_d;
  logic [DATA_WIDTH:0]   poly_q, poly_d;
  logic [PW-1:0]         rem_q, rem_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  fin_q, fin_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic                  m_valid_s;
  logic [PW-1:0]         cap_rem_s;
  logic [DATA_WIDTH:0]   cap_poly_s;
  logic [PW-1:0]         poly_ext_s;
  logic [IW-1:0]         shamt_s;
  logic [PW-1:0]         red_rem_s;
  logic [PW-1:0]         rem_new_s;
  logic [WW-1:0]         m_cur_s;
  logic [DATA_WIDTH-1:0] low_s;
  logic                  early_exit_s;

  // Capture-side masking: product keeps bits [2m-2:0], poly keeps bits [m-1:0].
  always_comb begin
    cap_rem_s  = '0;
    cap_poly_s = '0;
    m_valid_s  = (in_width != '0) && (int'(in_width) <= DATA_WIDTH);
    for (int i = 0; i < PW; i++) begin
      cap_rem_s[i] = (i < 2 * int'(in_width) - 1) ? in_product[i] : 1'b0;
    end
    for (int i = 0; i <= DATA_WIDTH; i++) begin
      cap_poly_s[i] = (i < int'(in_width)) ? in_poly[i] : 1'b0;
    end
  end

  // One reduction step: cancel the current top bit with the shifted modulus.
  always_comb begin
    poly_ext_s = PW'(poly_q) | (PW'(1) << m_q);
    shamt_s    = idx_q - IW'(m_q);
    red_rem_s  = rem_q[idx_q] ? (rem_q ^ (poly_ext_s << shamt_s)) : rem_q;
  end

  // Remainder and degree as they will be after this edge, used for the result
  // and for the early-exit test (capture in IDLE, reduction step otherwise).
  always_comb begin
    rem_new_s = (state_q == IDLE) ? cap_rem_s : red_rem_s;
    m_cur_s   = (state_q == IDLE) ? in_width : m_q;
    low_s     = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      low_s[i] = (i < int'(m_cur_s)) ? rem_new_s[i] : 1'b0;
    end
  end

`ifdef GF_REDUCE_EARLY_EXIT_EN
  // Nothing left at or above degree m means the remainder is already final.
  always_comb begin
    early_exit_s = 1'b1;
    for (int i = 0; i < PW; i++) begin
      early_exit_s = early_exit_s & ~((i >= int'(m_cur_s)) & rem_new_s[i]);
    end
  end
`else
  assign early_exit_s = 1'b0;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    poly_d  = poly_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    out_d   = out_q;
    fin_d   = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          m_d   = in_width;
          err_d = 1'b0;
          if (!m_valid_s) begin
            state_d = DONE;
            poly_d  = '0;
            rem_d   = '0;
            idx_d   = '0;
            out_d   = '0;
            fin_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            poly_d = cap_poly_s;
            rem_d  = cap_rem_s;
            idx_d  = IW'(2 * int'(in_width) - 2);
            // m=1 has nothing to reduce: the masked product is already rem[0].
            if ((in_width == WW'(1)) || early_exit_s) begin
              state_d = DONE;
              out_d   = low_s;
              fin_d   = 1'b1;
            end else begin
              state_d = REDUCE;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      REDUCE: begin
        rem_d = red_rem_s;
        idx_d = idx_q - IW'(1);
        if ((idx_q == IW'(m_q)) || early_exit_s) begin
          state_d = DONE;
          out_d   = low_s;
          fin_d   = 1'b1;
        end else begin
          state_d = REDUCE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      m_q     <= '0;
      poly_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      poly_q  <= poly_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign out_reduced = out_q;
  assign op_finish   = fin_q;
  assign out_error   = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_gf_reduce.sv
module tb_gf_reduce;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic [3:0]  in_width;
  logic [8:0]  in_poly;
  logic [15:0] in_product;
  logic [7:0]  out_reduced;
  logic        op_finish;
  logic        out_error;
  logic        busy;

`ifdef GF_REDUCE_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  gf_reduce #(.DATA_WIDTH(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .in_width    (in_width),
    .in_poly     (in_poly),
    .in_product  (in_product),
    .out_reduced (out_reduced),
    .op_finish   (op_finish),
    .out_error   (out_error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int m;
    int p;
    int x;
    int res;
    int err;
  } vec_t;

  typedef struct {
    int res;
    int err;
    int lat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[14];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Polynomial long division over GF(2): expected remainder, error and the
  // edge (capture = 1) on which op_finish is expected.
  function automatic void model(input int m, input int p, input int x,
                                output int res, output int err, output int lat);
    int  full;
    int  r;
    int  i;
    bit  done;
    if (m < 1 || m > 8) begin
      res = 0; err = 1; lat = 1;
      return;
    end
    err  = 0;
    full = (1 << m) | (p & ((1 << m) - 1));
    r    = x & ((1 << (2 * m - 1)) - 1);
    lat  = m;
    done = EARLY && ((r >> m) == 0);
    if (done) lat = 1;
    for (int e = 2; e <= m; e++) begin
      i = 2 * m - e;
      if (r[i]) r = r ^ (full << (i - m));
      if (!done && EARLY && ((r >> m) == 0)) begin
        done = 1'b1;
        lat  = e;
      end
    end
    res = r & ((1 << m) - 1);
  endfunction

  // One operation: push expectation, capture, scramble inputs, wait for finish.
  task automatic do_op(input string nm, input int m, input int p, input int x,
                       input int er, input int ee);
    exp_t e;
    exp_t got;
    int   mr, me, ml;
    int   edges;
    model(m, p, x, mr, me, ml);
    e.res = er; e.err = ee; e.lat = ml;
    sb.push_back(e);
    @(negedge clk);
    enable = 1'b1; in_width = 4'(m); in_poly = 9'(p); in_product = 16'(x);
    @(posedge clk); #1;
    edges = 1;
    enable = 1'b0;
    in_width = 4'($urandom); in_poly = 9'($urandom); in_product = 16'($urandom);
    chk({nm, "_busy"}, int'(busy), 1);
    while (!op_finish && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    got = sb.pop_front();
    if (!op_finish) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chk({nm, "_res"}, int'(out_reduced), got.res);
      chk({nm, "_err"}, int'(out_error), got.err);
      chk({nm, "_lat"}, edges, got.lat);
      @(posedge clk); #1;
      chk({nm, "_pulse"}, int'(op_finish), 0);
      chk({nm, "_idle"}, int'(busy), 0);
      chk({nm, "_errhold"}, int'(out_error), got.err);
    end
  endtask

  initial begin
    int   fin_cnt;
    int   edges;
    int   nseen;
    int   la, lb, r0, e0;
    exp_t got;

    tbl[0]  = '{8, 'h11B, 'h2B79, 'hC1, 0};
    tbl[1]  = '{4, 'h013, 'h0040, 'h0C, 0};
    tbl[2]  = '{8, 'h11B, 'h0005, 'h05, 0};
    tbl[3]  = '{0, 'h11B, 'h2B79, 'h00, 1};
    tbl[4]  = '{8, 'h11B, 'h0102, 'h19, 0};
    tbl[5]  = '{9, 'h11B, 'h2B79, 'h00, 1};
    tbl[6]  = '{1, 'h1FF, 'hFFFF, 'h01, 0};
    tbl[7]  = '{15, 'h013, 'h0040, 'h00, 1};
    tbl[8]  = '{2, 'h007, 'h000F, 'h00, 0};
    tbl[9]  = '{8, 'h11B, 'h8000, 'h00, 0};
    tbl[10] = '{3, 'h00B, 'h0010, 'h06, 0};
    tbl[11] = '{8, 'h01B, 'h2B79, 'hC1, 0};
    tbl[12] = '{4, 'h1F3, 'h0040, 'h0C, 0};
    tbl[13] = '{4, 'h013, 'h00FF, 'h06, 0};

    // Reset held with enable asserted: reset must win.
    resetn = 1'b0; enable = 1'b1; in_width = 4'd4; in_poly = 9'h013; in_product = 16'h0040;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_fin", int'(op_finish), 0);
    chk("rst_err", int'(out_error), 0);
    chk("rst_out", int'(out_reduced), 0);
    @(negedge clk);
    resetn = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", int'(busy), 0);

    foreach (tbl[k]) begin
      do_op($sformatf("vec%0d", k), tbl[k].m, tbl[k].p, tbl[k].x, tbl[k].res, tbl[k].err);
    end

    for (int k = 0; k < 20; k++) begin
      int m, p, x;
      m = int'($urandom_range(1, 8));
      p = int'($urandom_range(0, 511));
      x = int'($urandom_range(0, 65535));
      model(m, p, x, r0, e0, la);
      do_op($sformatf("rnd%0d", k), m, p, x, r0, e0);
    end

    // Back-to-back with enable held high throughout.
    model(4, 'h13, 'h0040, r0, e0, la);
    model(4, 'h13, 'h00FF, r0, e0, lb);
    got.res = 'h0C; got.err = 0; got.lat = la;
    sb.push_back(got);
    got.res = 'h06; got.err = 0; got.lat = la + 1 + lb;
    sb.push_back(got);
    @(negedge clk);
    enable = 1'b1; in_width = 4'd4; in_poly = 9'h013; in_product = 16'h0040;
    @(posedge clk); #1;
    edges = 1; nseen = 0;
    in_product = 16'h00FF;
    while (nseen < 2 && edges < 40) begin
      if (op_finish) begin
        got = sb.pop_front();
        chk($sformatf("b2b%0d_res", nseen), int'(out_reduced), got.res);
        chk($sformatf("b2b%0d_edge", nseen), edges, got.lat);
        nseen++;
        if (nseen == 2) enable = 1'b0;
      end
      if (nseen < 2) begin
        @(posedge clk); #1;
        edges++;
      end
    end
    enable = 1'b0;
    chk("b2b_count", nseen, 2);
    while (sb.size() > 0) void'(sb.pop_front());
    repeat (2) @(posedge clk);
    #1;

    // Reset at edge 3 of an m=8 operation aborts it.
    @(negedge clk);
    enable = 1'b1; in_width = 4'd8; in_poly = 9'h11B; in_product = 16'h4000;
    @(posedge clk); #1;
    fin_cnt = int'(op_finish);
    enable = 1'b0;
    @(posedge clk); #1;
    fin_cnt += int'(op_finish);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_out", int'(out_reduced), 0);
    chk("abort_err", int'(out_error), 0);
    chk("abort_fin", int'(op_finish), 0);
    resetn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      fin_cnt += int'(op_finish);
    end
    chk("abort_nofinish", fin_cnt, 0);
    do_op("post_abort", 8, 'h11B, 'h2B79, 'hC1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
